// File: rtl/transaction_arbiter_pkg.sv
// Shared transaction-layer definitions for the strict-priority arbiter and its
// word counters.
package transaction_arbiter_pkg;

    localparam int DATA_W   = 12;
    localparam int CNT_W    = 8;
    localparam int DEST_LSB = 10;
    localparam int NUM_FIFO = 4;
    localparam int NUM_CNT  = NUM_FIFO + 1;

    localparam logic [2:0] TOTAL_IDX = 3'd4;

    typedef logic [1:0] dest_t;

    function automatic logic [NUM_FIFO-1:0] dest_onehot(input dest_t d);
        dest_onehot    = '0;
        dest_onehot[d] = 1'b1;
    endfunction

endpackage

// File: rtl/transaction_arbiter_word_counters.sv
// Per-destination and total push counters with a one-cycle registered read port.
module word_counters
    import transaction_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_FIFO-1:0] push,
    input  logic                req,
    input  logic [2:0]          idx,
    output logic [CNT_W-1:0]    count_out,
    output logic                count_valid
);

    logic [CNT_W-1:0] cnt_q [NUM_CNT];
    logic [CNT_W-1:0] cnt_d [NUM_CNT];
    logic [CNT_W-1:0] count_out_d, count_out_q;
    logic             count_valid_d, count_valid_q;

    always_comb begin
        for (int k = 0; k < NUM_FIFO; k++) begin
            cnt_d[k] = cnt_q[k] + CNT_W'(push[k]);
        end
        cnt_d[TOTAL_IDX] = cnt_q[TOTAL_IDX] + CNT_W'(|push);
    end

    // Reads sample cnt_q, so a read racing an increment returns the old value.
    always_comb begin
        count_valid_d = 1'b0;
        count_out_d   = '0;
        if (req) begin
            case (idx)
                3'd0: begin count_valid_d = 1'b1; count_out_d = cnt_q[0]; end
                3'd1: begin count_valid_d = 1'b1; count_out_d = cnt_q[1]; end
                3'd2: begin count_valid_d = 1'b1; count_out_d = cnt_q[2]; end
                3'd3: begin count_valid_d = 1'b1; count_out_d = cnt_q[3]; end
                3'd4: begin count_valid_d = 1'b1; count_out_d = cnt_q[4]; end
                default: begin count_valid_d = 1'b0; count_out_d = '0; end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NUM_CNT; k++) begin
                cnt_q[k] <= '0;
            end
            count_out_q   <= '0;
            count_valid_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CNT; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            count_out_q   <= count_out_d;
            count_valid_q <= count_valid_d;
        end
    end

    assign count_out   = count_out_q;
    assign count_valid = count_valid_q;

endmodule

// File: rtl/transaction_arbiter.sv
// Strict-priority arbiter: pops the lowest-numbered non-empty input FIFO and
// pushes the word one cycle later to the output FIFO named by its dest field.
module transaction_arbiter
    import transaction_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [NUM_FIFO-1:0] in_empty,
    input  logic [DATA_W-1:0]   in_data0,
    input  logic [DATA_W-1:0]   in_data1,
    input  logic [DATA_W-1:0]   in_data2,
    input  logic [DATA_W-1:0]   in_data3,
    output logic [NUM_FIFO-1:0] in_pop,
    input  logic [NUM_FIFO-1:0] out_almost_full,
    output logic [NUM_FIFO-1:0] out_push,
    output logic [DATA_W-1:0]   out_data,
    input  logic                req,
    input  logic [2:0]          idx,
    output logic [CNT_W-1:0]    count_out,
    output logic                count_valid,
    output logic                idle
);

    // Handshake: a word transfers from input FIFO i when in_pop[i]=1 and
    // in_empty[i]=0 in the same cycle (head word is valid whenever empty=0).
    // Output FIFOs take out_data on every cycle out_push[k]=1; they give
    // backpressure only through almost_full, so one in-flight word must fit.
    logic                stall;
    logic [NUM_FIFO-1:0] grant;
    logic [DATA_W-1:0]   sel_data;
    dest_t               dest;
    logic [NUM_FIFO-1:0] out_push_d, out_push_q;
    logic [DATA_W-1:0]   out_data_d, out_data_q;
    logic                idle_d, idle_q;

    assign stall = |out_almost_full;

    always_comb begin
        grant    = '0;
        sel_data = '0;
        if (reset && enable && !stall) begin
            if (!in_empty[0]) begin
                grant    = 4'b0001;
                sel_data = in_data0;
            end else if (!in_empty[1]) begin
                grant    = 4'b0010;
                sel_data = in_data1;
            end else if (!in_empty[2]) begin
                grant    = 4'b0100;
                sel_data = in_data2;
            end else if (!in_empty[3]) begin
                grant    = 4'b1000;
                sel_data = in_data3;
            end
        end
    end

    assign dest = sel_data[DEST_LSB +: 2];

    always_comb begin
        out_push_d = '0;
        out_data_d = out_data_q;
        if (|grant) begin
            out_push_d = dest_onehot(dest);
            out_data_d = sel_data;
        end
        idle_d = (&in_empty) && !(|grant);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_push_q <= '0;
            out_data_q <= '0;
            idle_q     <= 1'b1;
        end else begin
            out_push_q <= out_push_d;
            out_data_q <= out_data_d;
            idle_q     <= idle_d;
        end
    end

    assign in_pop   = grant;
    assign out_push = out_push_q;
    assign out_data = out_data_q;
    assign idle     = idle_q;

    word_counters u_word_counters (
        .clk         (clk),
        .reset       (reset),
        .push        (out_push_q),
        .req         (req),
        .idx         (idx),
        .count_out   (count_out),
        .count_valid (count_valid)
    );

endmodule

// File: tb/tb_transaction_arbiter.sv
// Bench for transaction_arbiter: queue-modelled input FIFOs, push scoreboard
// and per-scenario tasks.
module tb_transaction_arbiter;
    import transaction_arbiter_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                enable;
    logic [NUM_FIFO-1:0] in_empty;
    logic [DATA_W-1:0]   in_data0, in_data1, in_data2, in_data3;
    logic [NUM_FIFO-1:0] in_pop;
    logic [NUM_FIFO-1:0] out_almost_full;
    logic [NUM_FIFO-1:0] out_push;
    logic [DATA_W-1:0]   out_data;
    logic                req;
    logic [2:0]          idx;
    logic [CNT_W-1:0]    count_out;
    logic                count_valid;
    logic                idle;

    always #5 clk = ~clk;

    transaction_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .in_empty        (in_empty),
        .in_data0        (in_data0),
        .in_data1        (in_data1),
        .in_data2        (in_data2),
        .in_data3        (in_data3),
        .in_pop          (in_pop),
        .out_almost_full (out_almost_full),
        .out_push        (out_push),
        .out_data        (out_data),
        .req             (req),
        .idx             (idx),
        .count_out       (count_out),
        .count_valid     (count_valid),
        .idle            (idle)
    );

    logic [DATA_W-1:0]   q0[$], q1[$], q2[$], q3[$];
    logic [15:0]         exp_q[$];
    logic [DATA_W-1:0]   last_data;
    logic [CNT_W-1:0]    cnt_m [NUM_CNT];
    int                  pop_log[$];
    int                  tests = 0;
    int                  fails = 0;

    function automatic int fsize(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] fhead(input int i);
        if (fsize(i) == 0) return '0;
        case (i)
            0: return q0[0];
            1: return q1[0];
            2: return q2[0];
            default: return q3[0];
        endcase
    endfunction

    function automatic int total_size();
        return q0.size() + q1.size() + q2.size() + q3.size();
    endfunction

    task automatic fpush(input int i, input logic [DATA_W-1:0] w);
        case (i)
            0: q0.push_back(w);
            1: q1.push_back(w);
            2: q2.push_back(w);
            default: q3.push_back(w);
        endcase
    endtask

    task automatic fpop(input int i);
        case (i)
            0: q0.delete(0);
            1: q1.delete(0);
            2: q2.delete(0);
            default: q3.delete(0);
        endcase
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < NUM_FIFO; i++) in_empty[i] = (fsize(i) == 0);
        in_data0 = fhead(0);
        in_data1 = fhead(1);
        in_data2 = fhead(2);
        in_data3 = fhead(3);
    endtask

    // One clock: check pop and scoreboard at negedge, update models, drive after posedge.
    task automatic cycle();
        logic [3:0]        exp_pop;
        logic [3:0]        oh;
        logic [15:0]       e;
        logic [DATA_W-1:0] w;
        int                sel;
        @(negedge clk);
        exp_pop = '0;
        w       = '0;
        sel     = -1;
        if (reset && enable && !(|out_almost_full)) begin
            for (int i = 0; i < NUM_FIFO; i++) begin
                if (sel < 0 && fsize(i) != 0) begin
                    sel        = i;
                    exp_pop[i] = 1'b1;
                    w          = fhead(i);
                end
            end
        end
        tests++;
        if (in_pop !== exp_pop) begin
            fails++;
            $display("FAIL in_pop: got %b expected %b at %0t", in_pop, exp_pop, $time);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            tests++;
            if ({out_push, out_data} !== e) begin
                fails++;
                $display("FAIL push: got push=%b data=%h expected push=%b data=%h at %0t",
                         out_push, out_data, e[15:12], e[11:0], $time);
            end
            if (reset) begin
                for (int k = 0; k < NUM_FIFO; k++) if (e[12+k]) cnt_m[k] = cnt_m[k] + 1'b1;
                if (|e[15:12]) cnt_m[4] = cnt_m[4] + 1'b1;
            end
        end
        if (!reset) begin
            for (int k = 0; k < NUM_CNT; k++) cnt_m[k] = '0;
            last_data = '0;
            exp_q.push_back(16'h0000);
            q0.delete(); q1.delete(); q2.delete(); q3.delete();
        end else if (sel >= 0) begin
            oh = 4'b0001 << w[DEST_LSB +: 2];
            last_data = w;
            exp_q.push_back({oh, w});
            pop_log.push_back(sel);
            fpop(sel);
        end else begin
            exp_q.push_back({4'b0000, last_data});
        end
        @(posedge clk);
        #1;
        drive_inputs();
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (total_size() != 0 && n < limit) begin
            cycle();
            n++;
        end
        tests++;
        if (total_size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d words left after %0d cycles, expected 0", total_size(), limit);
        end
        cycle();
        cycle();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b1; out_almost_full = '0; req = 1'b0; idx = '0;
        last_data = '0;
        for (int k = 0; k < NUM_CNT; k++) cnt_m[k] = '0;
        drive_inputs();
        repeat (3) cycle();
        reset = 1'b1;
        cycle();
        tests++; if (idle !== 1'b1) begin fails++; $display("FAIL reset_idle: got %b expected 1", idle); end
        tests++; if (out_push !== 4'b0000) begin fails++; $display("FAIL reset_push: got %b expected 0000", out_push); end
        tests++; if (out_data !== 12'h000) begin fails++; $display("FAIL reset_data: got %h expected 000", out_data); end
        tests++; if (count_valid !== 1'b0) begin fails++; $display("FAIL reset_cvalid: got %b expected 0", count_valid); end
        tests++; if (count_out !== 8'h00) begin fails++; $display("FAIL reset_cout: got %h expected 00", count_out); end
        tests++; if (in_pop !== 4'b0000) begin fails++; $display("FAIL reset_pop: got %b expected 0000", in_pop); end
    endtask

    task automatic test_routing();
        pop_log.delete();
        fpush(0, 12'h0AA); fpush(0, 12'h5CC); fpush(0, 12'hAF3); fpush(0, 12'hF77);
        drive_inputs();
        cycle();
        tests++; if (idle !== 1'b0) begin fails++; $display("FAIL routing_busy_idle: got %b expected 0", idle); end
        drain(20);
        tests++; if (pop_log.size() != 4) begin fails++; $display("FAIL routing_pops: got %0d expected 4", pop_log.size()); end
        tests++; if (idle !== 1'b1) begin fails++; $display("FAIL routing_idle: got %b expected 1", idle); end
    endtask

    task automatic test_priority();
        int exp_seq[8] = '{0, 0, 0, 2, 2, 2, 3, 3};
        pop_log.delete();
        fpush(0, 12'h001); fpush(0, 12'h402); fpush(0, 12'h803);
        fpush(2, 12'hC04); fpush(2, 12'h005); fpush(2, 12'h406);
        fpush(3, 12'h807); fpush(3, 12'hC08);
        drive_inputs();
        drain(40);
        tests++; if (pop_log.size() != 8) begin fails++; $display("FAIL priority_count: got %0d expected 8", pop_log.size()); end
        for (int i = 0; i < 8 && i < pop_log.size(); i++) begin
            tests++;
            if (pop_log[i] != exp_seq[i]) begin
                fails++;
                $display("FAIL priority_order[%0d]: got fifo %0d expected fifo %0d", i, pop_log[i], exp_seq[i]);
            end
        end
    endtask

    task automatic test_stall();
        pop_log.delete();
        fpush(0, 12'h52D); fpush(0, 12'h123); fpush(1, 12'h0FF);
        drive_inputs();
        cycle();
        out_almost_full = 4'b0010;
        repeat (3) cycle();
        tests++; if (pop_log.size() != 1) begin fails++; $display("FAIL stall_hold: got %0d pops expected 1", pop_log.size()); end
        tests++; if (in_pop !== 4'b0000) begin fails++; $display("FAIL stall_pop: got %b expected 0000", in_pop); end
        out_almost_full = 4'b0000;
        cycle();
        tests++; if (pop_log.size() != 2) begin fails++; $display("FAIL stall_resume: got %0d pops expected 2", pop_log.size()); end
        drain(20);
    endtask

    task automatic test_enable();
        logic [CNT_W-1:0] e;
        fpush(1, 12'h4A1); fpush(1, 12'hC52);
        drive_inputs();
        cycle();
        enable = 1'b0;
        repeat (3) cycle();
        tests++; if (in_pop !== 4'b0000) begin fails++; $display("FAIL enable_pop: got %b expected 0000", in_pop); end
        req = 1'b1; idx = 3'd4;
        e = cnt_m[4];
        cycle();
        req = 1'b0;
        tests++; if (count_valid !== 1'b1) begin fails++; $display("FAIL enable_read_valid: got %b expected 1", count_valid); end
        tests++; if (count_out !== e) begin fails++; $display("FAIL enable_read: got %0d expected %0d", count_out, e); end
        enable = 1'b1;
        drain(20);
    endtask

    task automatic load_per_dest(input int per_dest);
        for (int d = 0; d < NUM_FIFO; d++)
            for (int j = 0; j < per_dest; j++)
                fpush($urandom_range(0, 3), {2'(d), 10'($urandom_range(0, 1023))});
        drive_inputs();
    endtask

    task automatic read_all(input logic [CNT_W-1:0] each, input logic [CNT_W-1:0] total);
        logic [CNT_W-1:0] exp_v;
        for (int k = 0; k < NUM_CNT; k++) begin
            req = 1'b1; idx = 3'(k);
            cycle();
            exp_v = (k == 4) ? total : each;
            tests++; if (count_valid !== 1'b1) begin fails++; $display("FAIL cnt_valid[%0d]: got %b expected 1", k, count_valid); end
            tests++; if (count_out !== exp_v) begin fails++; $display("FAIL cnt[%0d]: got %0d expected %0d", k, count_out, exp_v); end
        end
        idx = 3'd5;
        cycle();
        tests++; if (count_valid !== 1'b0 || count_out !== 8'h00) begin
            fails++; $display("FAIL cnt_idx5: got valid=%b out=%0d expected valid=0 out=0", count_valid, count_out);
        end
        req = 1'b0; idx = 3'd0;
        cycle();
        tests++; if (count_valid !== 1'b0) begin fails++; $display("FAIL cnt_noreq: got %b expected 0", count_valid); end
    endtask

    task automatic test_counters();
        do_reset();
        load_per_dest(4);
        drain(40);
        read_all(8'd4, 8'd16);
        load_per_dest(4);
        drain(40);
        read_all(8'd8, 8'd32);
        fpush(0, 12'h011);
        drive_inputs();
        cycle();
        req = 1'b1; idx = 3'd0;
        cycle();
        tests++; if (count_out !== 8'd8) begin fails++; $display("FAIL cnt_race: got %0d expected 8", count_out); end
        cycle();
        tests++; if (count_out !== 8'd9) begin fails++; $display("FAIL cnt_after_race: got %0d expected 9", count_out); end
        req = 1'b0;
        cycle();
    endtask

    task automatic test_wrap();
        do_reset();
        for (int j = 0; j < 256; j++) fpush($urandom_range(0, 3), {2'd2, 10'($urandom_range(0, 1023))});
        drive_inputs();
        drain(400);
        req = 1'b1; idx = 3'd2;
        cycle();
        tests++; if (count_out !== 8'd0 || count_valid !== 1'b1) begin fails++; $display("FAIL wrap_cnt2: got %0d expected 0", count_out); end
        idx = 3'd4;
        cycle();
        tests++; if (count_out !== 8'd0 || count_valid !== 1'b1) begin fails++; $display("FAIL wrap_cnt4: got %0d expected 0", count_out); end
        req = 1'b0;
        cycle();
    endtask

    task automatic test_reset_mid();
        for (int j = 0; j < 6; j++) fpush(1, {2'(j), 10'($urandom_range(0, 1023))});
        drive_inputs();
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        tests++; if (out_push !== 4'b0000) begin fails++; $display("FAIL midreset_push: got %b expected 0000", out_push); end
        tests++; if (idle !== 1'b1) begin fails++; $display("FAIL midreset_idle: got %b expected 1", idle); end
        reset = 1'b1;
        cycle();
        read_all(8'd0, 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_routing();
        test_priority();
        test_stall();
        test_enable();
        test_counters();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/transaction_arbiter.md
Name: transaction_arbiter

Overview:
- Strict-priority arbiter for the transaction layer. Sits between the four input virtual-channel FIFOs and the four output ("azul") FIFOs.
- Each cycle it pops at most one word from the highest-priority non-empty input FIFO and pushes it to the output FIFO selected by the word's destination bits.
- Stalls on any output almost-full.
- Keeps per-destination and total word counters, readable through a req/idx interface.

Parameters:
- DATA_W, 12, word width.
- CNT_W, 8, counter width.
- DEST_LSB, 10, LSB of the 2-bit destination field (dest = word[DEST_LSB+1:DEST_LSB]).

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  arbitration enable.
- in_empty  in  4  empty flags of input FIFOs 0..3 (FIFO 0 = highest priority).
- in_data0..in_data3  in  DATA_W each  head word of each input FIFO; first-word-fall-through, valid while empty=0.
- in_pop  out  4  one-hot pop to input FIFOs (combinational).
- out_almost_full  in  4  almost-full flags of output FIFOs 0..3.
- out_push  out  4  one-hot push to output FIFOs (registered).
- out_data  out  DATA_W  word for output FIFOs (registered).
- req  in  1  counter read request.
- idx  in  3  counter index: 0..3 per destination, 4 = total.
- count_out  out  CNT_W  counter read data.
- count_valid  out  1  count_out valid.
- idle  out  1  all inputs empty and no push in flight.

Behaviour:
- Reset (reset=0 at posedge):
  - out_push=0, out_data=0, all counters=0, count_out=0, count_valid=0, idle=1.
  - in_pop forced 0 while reset=0.
- stall = |out_almost_full.
- in_pop[i]=1 iff all of:
  - reset=1 and enable=1 and stall=0;
  - in_empty[i]=0;
  - in_empty[j]=1 for all j<i.
- At most one in_pop bit set per cycle.
- Push:
  - If in_pop[i]=1 in cycle N, then in cycle N+1 out_push[dest(in_data_i)]=1 and out_data=in_data_i.
  - Latency is exactly 1 cycle.
  - Otherwise out_push=0 and out_data holds its last value.
- Sustained throughput: 1 word/cycle.
- In-flight word: a word popped in the cycle almost_full rises is still pushed next cycle. Output FIFOs must keep at least 1 entry of margin above umbral_alto.
- enable=0:
  - No new pops.
  - An already-registered push still completes.
  - Counter reads still work.
- Counters:
  - cnt[k] increments on each cycle out_push[k]=1.
  - cnt[4] increments on any out_push.
  - All are CNT_W wide, wrap 2^CNT_W-1 -> 0.
  - Invariant: cnt[4] == (cnt0+cnt1+cnt2+cnt3) mod 2^CNT_W.
- Counter read:
  - req=1 with idx 0..4 at edge N: at N+1, count_valid=1 and count_out = value of cnt[idx] before edge N's increment.
  - idx 5..7: count_valid=0, count_out=0.
  - req=0: count_valid=0, count_out=0.
  - Back-to-back reads allowed, one per cycle.
- idle (registered): 1 when in_empty==4'hF and no push will occur next cycle.
- Reset mid-operation: a word popped in the cycle before the reset edge is dropped (no push). Counters clear; the upstream FIFOs are reset by the same signal.
- Simultaneous push increment and read of the same counter: the read returns the pre-increment value.

Decomposition:
- Shared package (transaction layer): DATA_W, CNT_W, DEST_LSB, NUM_FIFO=4, TOTAL_IDX=3'd4.
- One sub-module, word_counters: five CNT_W counters plus the req/idx read port. It is driven by out_push.
- Priority select and push registers stay in the top module.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles, then release with all in_empty=1 -> idle=1, outputs 0, no pops.
- Routing: FIFO0 heads 0x0AA, 0x5CC, 0xAF3, 0xF77 -> pushes to out_push 0001, 0010, 0100, 1000 with matching out_data, each exactly 1 cycle after its pop.
- Priority: FIFOs 0 and 2 both non-empty -> FIFO0 drains fully before any in_pop[2]. Then FIFO3 waits for FIFO2 to drain.
- Stall:
  - Raise out_almost_full[1] in the cycle FIFO0 pops 0x52D -> 0x52D is still pushed.
  - No further pops on any input while the flag is high.
  - Resume the cycle after it drops.
- Counters:
  - Route 4 words to each destination (16 total) -> reads idx 0..3 = 4 each, idx 4 = 16, idx 5 -> count_valid=0.
  - Repeat -> 8 and 32.
- Wrap/reset:
  - 256 words to destination 2 -> cnt2=0, cnt4=0.
  - Assert reset mid-stream -> popped-but-unpushed word is not pushed, all counters read 0.
